// File: rtl/bandai2003_pkg.sv
// Shared constants and types for the BANDAI2003 mapper bring-up sequencer:
// bus addresses, the expected SO bitstream, FSM states and error codes.
package bandai2003_pkg;

  localparam logic [7:0] ADDR_IDLE  = 8'h00;
  localparam logic [7:0] ADDR_ACK   = 8'h5A;
  localparam logic [7:0] ADDR_NAK   = 8'hA5;
  localparam logic [7:0] ADDR_LAO   = 8'hC0;
  localparam logic [7:0] ADDR_BRAM  = 8'hC1;
  localparam logic [7:0] ADDR_BROM0 = 8'hC2;
  localparam logic [7:0] ADDR_BROM1 = 8'hC3;

  // Word the mapper shifts out on SO after unlock, bit 0 first.
  localparam int              BS_W = 18;
  localparam logic [BS_W-1:0] BS   = {1'b0, 16'h28A0, 1'b0};

  typedef enum logic [3:0] {
    ST_IDLE  = 4'd0,
    ST_UNLK0 = 4'd1,
    ST_UNLK1 = 4'd2,
    ST_STRM  = 4'd3,
    ST_WSET  = 4'd4,
    ST_WSTB  = 4'd5,
    ST_WHOLD = 4'd6,
    ST_RSET  = 4'd7,
    ST_RWAIT = 4'd8,
    ST_RCMP  = 4'd9,
    ST_NEXT  = 4'd10,
    ST_DONE  = 4'd11,
    ST_FAIL  = 4'd12
  } state_e;

  typedef enum logic [2:0] {
    ERR_NONE      = 3'd0,
    ERR_BITSTREAM = 3'd1,
    ERR_READBACK  = 3'd2
  } err_code_e;

  function automatic logic [7:0] bank_addr(input logic [1:0] idx);
    case (idx)
      2'd0:    return ADDR_LAO;
      2'd1:    return ADDR_BRAM;
      2'd2:    return ADDR_BROM0;
      default: return ADDR_BROM1;
    endcase
  endfunction

endpackage

// File: rtl/bandai_so_checker.sv
// Collects the 18-bit SO bitstream (LSB first) over the 18 edges following a
// start strobe; done/match are valid combinationally in the last bit's cycle.
module bandai_so_checker
  import bandai2003_pkg::*;
(
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_start,
  input  logic i_so,
  output logic o_done,
  output logic o_match
);

  logic [BS_W-2:0] r_shift;
  logic [4:0]      r_cnt;
  logic            r_active;
  logic [BS_W-1:0] w_word;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_shift  <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_shift <= {i_so, r_shift[BS_W-2:1]};
      r_cnt   <= r_cnt + 5'd1;
      if (r_cnt == 5'(BS_W - 1)) r_active <= 1'b0;
    end
  end

  // The final bit is still on SO, so it joins the word without a register stage.
  assign w_word  = {i_so, r_shift};
  assign o_done  = r_active && (r_cnt == 5'(BS_W - 1));
  assign o_match = o_done && (w_word == BS);

endmodule

// File: rtl/bandai_cfg_seq.sv
// BANDAI2003 bring-up sequencer: unlock, SO bitstream check, bank writes C0h-C3h.
// Define BANDAI_CFG_VERIFY_EN to add per-bank readback verification.
module bandai_cfg_seq
  import bandai2003_pkg::*;
#(
  parameter int WR_PULSE = 2,
  parameter int RD_WAIT  = 2
) (
  input  logic       CLK,
  input  logic       RSTn,
  input  logic       START,
  input  logic [7:0] BANK_LAO,
  input  logic [7:0] BANK_RAM,
  input  logic [7:0] BANK_ROM0,
  input  logic [7:0] BANK_ROM1,
  output logic       BUSY,
  output logic       DONE,
  output logic       ERR,
  output logic [2:0] ERR_CODE,
  output logic [1:0] ERR_IDX,
  output logic       CEn,
  output logic       SSn,
  output logic       WEn,
  output logic       OEn,
  output logic [7:0] ADDR,
  output logic [7:0] DQ_O,
  output logic       DQ_OE,
  input  logic [7:0] DQ_I,
  input  logic       SO,
  output state_e     o_dbg_state
);

  localparam logic [7:0] WR_LAST = 8'(WR_PULSE - 1);
  localparam logic [7:0] RD_LAST = 8'(RD_WAIT - 1);

  state_e     r_state, w_next;
  logic [1:0] r_idx;
  logic [7:0] r_wait;
  logic       r_unlocked, r_done, r_err;
  err_code_e  r_err_code;
  logic [1:0] r_err_idx;
  logic [7:0] r_bank [4];
  logic       w_accept, w_so_done, w_so_match;
  logic [7:0] w_bank;

`ifdef BANDAI_CFG_VERIFY_EN
  logic [7:0] r_rd_data;
`else
  logic w_unused_dq;
  assign w_unused_dq = ^DQ_I;
`endif

  assign w_bank = r_bank[r_idx];

  bandai_so_checker u_so_checker (
    .i_clk   (CLK),
    .i_rst_n (RSTn),
    .i_start (r_state == ST_UNLK1),
    .i_so    (SO),
    .o_done  (w_so_done),
    .o_match (w_so_match)
  );

  always_ff @(posedge CLK) begin
    if (!RSTn) begin
      r_state    <= ST_IDLE;
      r_idx      <= 2'd0;
      r_wait     <= 8'd0;
      r_unlocked <= 1'b0;
      r_done     <= 1'b0;
      r_err      <= 1'b0;
      r_err_code <= ERR_NONE;
      r_err_idx  <= 2'd0;
      for (int i = 0; i < 4; i++) r_bank[i] <= 8'h00;
    end else begin
      r_state <= w_next;
      // Wait counter restarts on every state change so WSTB/RWAIT count from 0.
      r_wait  <= (w_next != r_state) ? 8'd0 : r_wait + 8'd1;
      if (w_accept) begin
        r_bank[0]  <= BANK_LAO;
        r_bank[1]  <= BANK_RAM;
        r_bank[2]  <= BANK_ROM0;
        r_bank[3]  <= BANK_ROM1;
        r_idx      <= 2'd0;
        r_done     <= 1'b0;
        r_err      <= 1'b0;
        r_err_code <= ERR_NONE;
      end
      if (r_state == ST_UNLK1) r_unlocked <= 1'b1;
      if (r_state == ST_STRM && w_so_done && !w_so_match) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_BITSTREAM;
      end
      if (r_state == ST_NEXT) begin
        if (r_idx == 2'd3) r_done <= 1'b1;
        else               r_idx  <= r_idx + 2'd1;
      end
`ifdef BANDAI_CFG_VERIFY_EN
      if (r_state == ST_RWAIT && r_wait == RD_LAST) r_rd_data <= DQ_I;
      if (r_state == ST_RCMP && r_rd_data != w_bank) begin
        r_err      <= 1'b1;
        r_err_code <= ERR_READBACK;
        r_err_idx  <= r_idx;
      end
`endif
    end
  end

  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    BUSY     = 1'b1;
    CEn      = 1'b1;
    SSn      = 1'b1;
    WEn      = 1'b1;
    OEn      = 1'b1;
    ADDR     = ADDR_IDLE;
    DQ_O     = 8'h00;
    DQ_OE    = 1'b0;
    case (r_state)
      ST_IDLE, ST_DONE, ST_FAIL: begin
        BUSY = 1'b0;
        if (START) begin
          w_accept = 1'b1;
          w_next   = r_unlocked ? ST_WSET : ST_UNLK0;
        end
      end
      ST_UNLK0: begin
        ADDR   = ADDR_ACK;
        w_next = ST_UNLK1;
      end
      ST_UNLK1: begin
        ADDR   = ADDR_NAK;
        w_next = ST_STRM;
      end
      ST_STRM: begin
        if (w_so_done) w_next = w_so_match ? ST_WSET : ST_FAIL;
      end
      ST_WSET: begin
        CEn    = 1'b0;
        ADDR   = bank_addr(r_idx);
        DQ_OE  = 1'b1;
        DQ_O   = w_bank;
        w_next = ST_WSTB;
      end
      ST_WSTB: begin
        CEn   = 1'b0;
        ADDR  = bank_addr(r_idx);
        DQ_OE = 1'b1;
        DQ_O  = w_bank;
        WEn   = 1'b0;
        if (r_wait == WR_LAST) w_next = ST_WHOLD;
      end
      ST_WHOLD: begin
        CEn   = 1'b0;
        ADDR  = bank_addr(r_idx);
        DQ_OE = 1'b1;
        DQ_O  = w_bank;
`ifdef BANDAI_CFG_VERIFY_EN
        w_next = ST_RSET;
`else
        w_next = ST_NEXT;
`endif
      end
      ST_RSET: begin
        CEn    = 1'b0;
        ADDR   = bank_addr(r_idx);
        w_next = ST_RWAIT;
      end
      ST_RWAIT: begin
        CEn  = 1'b0;
        ADDR = bank_addr(r_idx);
`ifdef BANDAI_CFG_VERIFY_EN
        OEn  = 1'b0;
`endif
        if (r_wait == RD_LAST) w_next = ST_RCMP;
      end
      ST_RCMP: begin
`ifdef BANDAI_CFG_VERIFY_EN
        w_next = (r_rd_data == w_bank) ? ST_NEXT : ST_FAIL;
`else
        w_next = ST_NEXT;
`endif
      end
      ST_NEXT: begin
        w_next = (r_idx == 2'd3) ? ST_DONE : ST_WSET;
      end
      default: w_next = ST_IDLE;
    endcase
  end

  assign DONE        = r_done;
  assign ERR         = r_err;
  assign ERR_CODE    = r_err_code;
  assign ERR_IDX     = r_err_idx;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_bandai_cfg_seq.sv
// Bench for bandai_cfg_seq with a behavioural BANDAI2003 mapper model.
// Honours BANDAI_CFG_VERIFY_EN for latency and the readback-fault scenario.
module tb_bandai_cfg_seq;
  import bandai2003_pkg::*;

  localparam int WR = 2;
  localparam int RD = 2;
`ifdef BANDAI_CFG_VERIFY_EN
  localparam int BANK_CYC = 5 + WR + RD;
`else
  localparam int BANK_CYC = 3 + WR;
`endif
  localparam int LAT_FULL     = 21 + 4 * BANK_CYC;
  localparam int LAT_UNLOCKED = 1 + 4 * BANK_CYC;
  localparam int LAT_BS_FAIL  = 21;
  localparam logic [17:0] TB_BS = {1'b0, 16'h28A0, 1'b0};

  // clock / reset
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic       START;
  logic [7:0] BANK_LAO, BANK_RAM, BANK_ROM0, BANK_ROM1;
  logic       BUSY, DONE, ERR, CEn, SSn, WEn, OEn, DQ_OE, SO;
  logic [2:0] ERR_CODE;
  logic [1:0] ERR_IDX;
  logic [7:0] ADDR, DQ_O, DQ_I;
  state_e     dbg_state;

  bandai_cfg_seq #(.WR_PULSE(WR), .RD_WAIT(RD)) dut (
    .CLK(CLK), .RSTn(RSTn), .START(START),
    .BANK_LAO(BANK_LAO), .BANK_RAM(BANK_RAM), .BANK_ROM0(BANK_ROM0), .BANK_ROM1(BANK_ROM1),
    .BUSY(BUSY), .DONE(DONE), .ERR(ERR), .ERR_CODE(ERR_CODE), .ERR_IDX(ERR_IDX),
    .CEn(CEn), .SSn(SSn), .WEn(WEn), .OEn(OEn), .ADDR(ADDR), .DQ_O(DQ_O), .DQ_OE(DQ_OE),
    .DQ_I(DQ_I), .SO(SO), .o_dbg_state(dbg_state)
  );

  // mapper model
  logic       force_bit5 = 1'b0;
  logic       corrupt_c2 = 1'b0;
  logic [17:0] m_bs;
  logic [7:0] m_prev_addr = 8'h00;
  logic       m_unlocked = 1'b0;
  logic [4:0] m_so_cnt = 5'd0;
  logic [7:0] m_regs [4];

  assign m_bs = TB_BS | (force_bit5 ? 18'h00020 : 18'h00000);
  assign DQ_I = (!CEn && !OEn && ADDR[7:2] == 6'b110000)
              ? ((corrupt_c2 && ADDR[1:0] == 2'd2) ? 8'h00 : m_regs[ADDR[1:0]]) : 8'hFF;

  always @(posedge CLK) begin
    m_prev_addr <= ADDR;
    if (!RSTn) begin
      m_unlocked <= 1'b0;
      m_so_cnt   <= 5'd0;
      SO         <= 1'b0;
      for (int i = 0; i < 4; i++) m_regs[i] <= 8'h00;
    end else begin
      if (m_prev_addr == 8'h5A && ADDR == 8'hA5) begin
        m_unlocked <= 1'b1;
        m_so_cnt   <= 5'd1;
        SO         <= m_bs[0];
      end else if (m_so_cnt != 5'd0 && m_so_cnt < 5'd18) begin
        SO       <= m_bs[m_so_cnt];
        m_so_cnt <= m_so_cnt + 5'd1;
      end else begin
        SO       <= 1'b0;
        m_so_cnt <= 5'd0;
      end
      if (m_unlocked && !CEn && !WEn && DQ_OE && ADDR[7:2] == 6'b110000)
        m_regs[ADDR[1:0]] <= DQ_O;
    end
  end

  // bus monitor (independent of reset)
  logic        m_prev_wen = 1'b1;
  int          m_wr_cnt = 0;
  int          m_unlk_seen = 0;
  int          m_both_low = 0;
  logic [15:0] obs_log [64];

  always @(posedge CLK) begin
    m_prev_wen <= WEn;
    if (!WEn && m_prev_wen) begin
      obs_log[m_wr_cnt % 64] <= {ADDR, DQ_O};
      m_wr_cnt <= m_wr_cnt + 1;
    end
    if (ADDR == 8'h5A || ADDR == 8'hA5) m_unlk_seen <= m_unlk_seen + 1;
    if (!WEn && !OEn) m_both_low <= m_both_low + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // scoreboard
  logic [15:0] exp_q[$];
  int n_cmp = 0;
  int n_fail = 0;
  int wr_snap = 0;
  int unlk_snap = 0;
  int cyc;
  int n;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic snap();
    wr_snap   = m_wr_cnt;
    unlk_snap = m_unlk_seen;
  endtask

  task automatic sb_drain(input string tag, input int exp_writes);
    int got;
    logic [15:0] e;
    got = m_wr_cnt - wr_snap;
    check({tag, "_write_count"}, got, exp_writes);
    for (int i = 0; i < got && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      check({tag, "_write"}, obs_log[(wr_snap + i) % 64], e);
    end
    exp_q.delete();
    wr_snap = m_wr_cnt;
  endtask

  task automatic drive_banks(input logic [7:0] b0, b1, b2, b3);
    BANK_LAO = b0; BANK_RAM = b1; BANK_ROM0 = b2; BANK_ROM1 = b3;
    exp_q.push_back({8'hC0, b0});
    exp_q.push_back({8'hC1, b1});
    exp_q.push_back({8'hC2, b2});
    exp_q.push_back({8'hC3, b3});
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RSTn = 1'b0;
    repeat (2) @(negedge CLK);
    RSTn = 1'b1;
  endtask

  // Drives START for one cycle, counts edges from the one that samples START
  // until DONE or ERR is seen.
  task automatic run_seq(input logic [7:0] b0, b1, b2, b3, input bit poke, output int c);
    @(negedge CLK);
    drive_banks(b0, b1, b2, b3);
    START = 1'b1;
    c = 0;
    while (c < 300) begin
      @(negedge CLK);
      c++;
      START = 1'b0;
      if (poke && c == 10) begin
        START = 1'b1;
        BANK_LAO = 8'h11; BANK_RAM = 8'h22; BANK_ROM0 = 8'h33; BANK_ROM1 = 8'h44;
      end
      if (DONE || ERR) break;
    end
    START = 1'b0;
  endtask

  task automatic expect_done(input string tag, input int c, input int lat, input int unlk,
                             input logic [7:0] e0, e1, e2, e3);
    check({tag, "_done"}, DONE, 1'b1);
    check({tag, "_err"}, ERR, 1'b0);
    check({tag, "_err_code"}, ERR_CODE, 3'd0);
    check({tag, "_busy"}, BUSY, 1'b0);
    check({tag, "_latency"}, c, lat);
    check({tag, "_unlock_addr_cycles"}, m_unlk_seen - unlk_snap, unlk);
    check({tag, "_reg_c0"}, m_regs[0], e0);
    check({tag, "_reg_c1"}, m_regs[1], e1);
    check({tag, "_reg_c2"}, m_regs[2], e2);
    check({tag, "_reg_c3"}, m_regs[3], e3);
    sb_drain(tag, 4);
  endtask

  initial begin
    START = 1'b0;
    BANK_LAO = 8'h00; BANK_RAM = 8'h00; BANK_ROM0 = 8'h00; BANK_ROM1 = 8'h00;
    RSTn = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_cen", CEn, 1'b1);
    check("rst_ssn", SSn, 1'b1);
    check("rst_wen", WEn, 1'b1);
    check("rst_oen", OEn, 1'b1);
    check("rst_addr", ADDR, 8'h00);
    check("rst_dq_o", DQ_O, 8'h00);
    check("rst_dq_oe", DQ_OE, 1'b0);
    check("rst_busy", BUSY, 1'b0);
    check("rst_done", DONE, 1'b0);
    check("rst_err", ERR, 1'b0);
    check("rst_err_code", ERR_CODE, 3'd0);
    check("rst_err_idx", ERR_IDX, 2'd0);
    RSTn = 1'b1;

    // cold start with unlock
    snap();
    run_seq(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, cyc);
    expect_done("cold", cyc, LAT_FULL, 2, 8'h12, 8'h34, 8'h56, 8'h78);

    // restart after DONE: already unlocked
    snap();
    run_seq(8'h9A, 8'hBC, 8'hDE, 8'hF0, 1'b0, cyc);
    expect_done("warm", cyc, LAT_UNLOCKED, 0, 8'h9A, 8'hBC, 8'hDE, 8'hF0);

    // START pulsed while busy with different bank inputs
    snap();
    run_seq(8'h01, 8'h02, 8'h03, 8'h04, 1'b1, cyc);
    expect_done("busy_poke", cyc, LAT_UNLOCKED, 0, 8'h01, 8'h02, 8'h03, 8'h04);

    // reset in the middle of a write strobe
    snap();
    @(negedge CLK);
    drive_banks(8'hAA, 8'hBB, 8'hCC, 8'hDD);
    START = 1'b1;
    @(negedge CLK);
    START = 1'b0;
    n = 0;
    while (dbg_state != ST_WSTB && n < 100) begin
      @(negedge CLK);
      n++;
    end
    check("abort_reach_wstb", dbg_state, ST_WSTB);
    RSTn = 1'b0;
    @(negedge CLK);
    check("abort_wen", WEn, 1'b1);
    check("abort_cen", CEn, 1'b1);
    check("abort_dq_oe", DQ_OE, 1'b0);
    check("abort_busy", BUSY, 1'b0);
    RSTn = 1'b1;
    check("abort_mapper_c0", m_regs[0], 8'h00);
    sb_drain("abort", 1);

    // first START after reset must unlock again
    snap();
    run_seq(8'h21, 8'h43, 8'h65, 8'h87, 1'b0, cyc);
    expect_done("relock", cyc, LAT_FULL, 2, 8'h21, 8'h43, 8'h65, 8'h87);

    // bitstream bit 5 corrupted
    do_reset();
    force_bit5 = 1'b1;
    snap();
    run_seq(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, cyc);
    check("bs_err", ERR, 1'b1);
    check("bs_err_code", ERR_CODE, 3'd1);
    check("bs_done", DONE, 1'b0);
    check("bs_busy", BUSY, 1'b0);
    check("bs_latency", cyc, LAT_BS_FAIL);
    sb_drain("bs", 0);
    force_bit5 = 1'b0;

`ifdef BANDAI_CFG_VERIFY_EN
    // C2h readback corrupted
    do_reset();
    corrupt_c2 = 1'b1;
    snap();
    run_seq(8'h12, 8'h34, 8'h56, 8'h78, 1'b0, cyc);
    check("rb_err", ERR, 1'b1);
    check("rb_err_code", ERR_CODE, 3'd2);
    check("rb_err_idx", ERR_IDX, 2'd2);
    check("rb_done", DONE, 1'b0);
    check("rb_latency", cyc, 21 + 2 * BANK_CYC + 4 + WR + RD);
    check("rb_reg_c2", m_regs[2], 8'h56);
    check("rb_reg_c3", m_regs[3], 8'h00);
    sb_drain("rb", 3);
    corrupt_c2 = 1'b0;
`endif

    check("we_oe_overlap_cycles", m_both_low, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
